mem_wb_stage: RTL and testbench
===============================

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: ACCESS cycles without mem_ack before abort; used only under MEM_TIMEOUT_EN; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 valid_in  input  1  stage-3 register holds a live instruction.
REQ-005 reg_we_in, store_pc_in, mem_bypass_in, mem_we_in, aux_in  input  1 each  stage-3 controls: register write, link write, skip memory, store (vs load), byte access.
REQ-006 wa_in  input  5  destination register address.
REQ-007 alu_in, sdata_in, pc_in  input  16 each  ALU result/memory address, store data, link value.
REQ-008 mem_req, mem_wr  output  1 each  data-memory request; write strobe.
REQ-009 mem_addr, mem_wdata  output  16 each  address; write data.
REQ-010 mem_be  output  2  byte enables.
REQ-011 mem_ack  input  1  memory completed current request.
REQ-012 mem_rdata  input  16  read data, valid when mem_ack=1.
REQ-013 stall_out  output  1  upstream SHALL hold its registers while 1.
REQ-014 wb_valid, wb_we  output  1 each  writeback slot live; register-file write enable.
REQ-015 wb_addr  output  5  writeback register address.
REQ-016 wb_data  output  16  writeback value.
REQ-017 err_out  output  1  one-cycle pulse on memory timeout.

Function
REQ-018 FSM states: IDLE and ACCESS only.
REQ-019 IDLE, valid_in=1, mem_bypass_in=1: SHALL register result; next cycle wb_valid=1, wb_we=reg_we_in, wb_addr=wa_in, wb_data=pc_in if store_pc_in else alu_in (latency 1).
REQ-020 IDLE, valid_in=1, mem_bypass_in=0: SHALL latch controls, address, data; go to ACCESS; mem_req=1 from next cycle.
REQ-021 In ACCESS, mem_req, mem_wr=mem_we, mem_addr, mem_wdata, mem_be SHALL be registered and held stable until the mem_ack cycle.
REQ-022 Word access (aux=0): mem_be=2'b11, mem_wdata=sdata, load data=mem_rdata.
REQ-023 Byte access (aux=1): mem_be=2'b10 if addr[0]=1 else 2'b01; store replicates sdata[7:0] in both bytes; load zero-extends the selected byte.
REQ-024 ACCESS with mem_ack=1: SHALL capture data, return to IDLE; next cycle wb_valid=1, wb_data=load data (load) or alu (store), wb_we=reg_we AND NOT mem_we.
REQ-025 stall_out SHALL equal (state==ACCESS AND mem_ack=0); upstream instruction presented in the ack cycle SHALL be accepted that same cycle.
REQ-026 wb_valid SHALL be a one-cycle pulse per retired instruction; wb_we=0 whenever wb_valid=0.
REQ-027 mem_ack while IDLE SHALL be ignored; valid_in while stall_out=1 SHALL NOT be consumed.

Reset
REQ-028 rst=1 at an edge: state=IDLE; mem_req, mem_wr, mem_be, mem_addr, mem_wdata, stall_out, wb_valid, wb_we, wb_addr, wb_data, err_out all 0; timeout counter 0.
REQ-029 rst during ACCESS SHALL abort the access without writeback; late mem_ack after reset SHALL be ignored.

Configuration
REQ-030 Macro MEM_TIMEOUT_EN defined: 8-bit counter increments each ACCESS cycle without ack; on reaching TIMEOUT_CYCLES, mem_req drops, state returns IDLE, err_out pulses 1 cycle, wb_valid pulses with wb_we=0; ack on the same cycle as expiry SHALL win (normal completion).
REQ-031 MEM_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; err_out tied 0.

Verification
REQ-032 Bypass: valid_in=1, bypass=1, alu_in=16'h1234, wa_in=5, reg_we=1 -> next cycle wb_valid=1, wb_addr=5, wb_data=16'h1234, stall_out never 1.
REQ-033 Word load, ack after 3 cycles, mem_rdata=16'hBEEF -> mem_req high 3 cycles, stall_out 1 for 2, wb_data=16'hBEEF cycle after ack.
REQ-034 Byte store addr=16'h0011, sdata=16'h00AB -> mem_be=2'b10, mem_wdata=16'hABAB, mem_wr=1, wb_we=0.
REQ-035 Byte load addr=16'h0010, mem_rdata=16'h7F80, immediate ack -> wb_data=16'h0080; back-to-back bypass accepted in ack cycle.
REQ-036 MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_req drops after 4 cycles, err_out=1 one cycle, wb_we=0; rst mid-ACCESS -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: bypass retires in 1 cycle, loads/stores retire the cycle after mem_ack; stall_out holds upstream while ACCESS waits.
// Optional memory timeout abort when MEM_TIMEOUT_EN is defined (TIMEOUT_CYCLES, 1..255).
module mem_wb_stage #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic        reg_we_in,
  input  logic        store_pc_in,
  input  logic        mem_bypass_in,
  input  logic        mem_we_in,
  input  logic        aux_in,
  input  logic [4:0]  wa_in,
  input  logic [15:0] alu_in,
  input  logic [15:0] sdata_in,
  input  logic [15:0] pc_in,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        stall_out,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_addr,
  output logic [15:0] wb_data,
  output logic        err_out
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..255");
  end

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d, mem_wr_q, mem_wr_d;
  logic [15:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [1:0]  mem_be_q, mem_be_d;
  logic        lreg_we_q, lreg_we_d, laux_q, laux_d;
  logic [4:0]  lwa_q, lwa_d;
  logic        wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [15:0] wb_data_q, wb_data_d;
  logic        err_q, err_d;
  logic        pend_vld_q, pend_vld_d, pend_we_q, pend_we_d;
  logic [4:0]  pend_addr_q, pend_addr_d;
  logic [15:0] pend_data_q, pend_data_d;
  logic        ack_now, accept, slot_used;
  logic [7:0]  byte_sel;
  logic [15:0] load_data, bypass_data;
`ifdef MEM_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
`endif

  assign stall_out = (state_q == ACCESS) && !mem_ack;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    lreg_we_d   = lreg_we_q;
    laux_d      = laux_q;
    lwa_d       = lwa_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = 1'b0;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    err_d       = 1'b0;
    pend_vld_d  = pend_vld_q;
    pend_we_d   = pend_we_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    slot_used   = 1'b0;
    ack_now     = (state_q == ACCESS) && mem_ack;
    accept      = valid_in && ((state_q == IDLE) || mem_ack);
    byte_sel    = mem_addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0];
    load_data   = laux_q ? {8'h00, byte_sel} : mem_rdata;
    bypass_data = store_pc_in ? pc_in : alu_in;
`ifdef MEM_TIMEOUT_EN
    cnt_d = cnt_q;
`endif

    if (ack_now) begin
      wb_valid_d = 1'b1;
      wb_we_d    = lreg_we_q & ~mem_wr_q;
      wb_addr_d  = lwa_q;
      wb_data_d  = mem_wr_q ? mem_addr_q : load_data;
      slot_used  = 1'b1;
      state_d    = IDLE;
      mem_req_d  = 1'b0;
      mem_wr_d   = 1'b0;
      mem_be_d   = 2'b00;
    end else if (pend_vld_q) begin
      wb_valid_d = 1'b1;
      wb_we_d    = pend_we_q;
      wb_addr_d  = pend_addr_q;
      wb_data_d  = pend_data_q;
      pend_vld_d = 1'b0;
      slot_used  = 1'b1;
    end

`ifdef MEM_TIMEOUT_EN
    if ((state_q == ACCESS) && !mem_ack) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_d == 8'(TIMEOUT_CYCLES)) begin
        cnt_d      = 8'd0;
        state_d    = IDLE;
        mem_req_d  = 1'b0;
        mem_wr_d   = 1'b0;
        mem_be_d   = 2'b00;
        err_d      = 1'b1;
        wb_valid_d = 1'b1;
        wb_we_d    = 1'b0;
        wb_addr_d  = lwa_q;
        wb_data_d  = mem_addr_q;
      end
    end
`endif

    // A bypass accepted while the writeback slot is taken (ack cycle) retires one cycle later.
    if (accept) begin
      if (mem_bypass_in) begin
        if (slot_used) begin
          pend_vld_d  = 1'b1;
          pend_we_d   = reg_we_in;
          pend_addr_d = wa_in;
          pend_data_d = bypass_data;
        end else begin
          wb_valid_d = 1'b1;
          wb_we_d    = reg_we_in;
          wb_addr_d  = wa_in;
          wb_data_d  = bypass_data;
        end
      end else begin
        state_d     = ACCESS;
        mem_req_d   = 1'b1;
        mem_wr_d    = mem_we_in;
        mem_addr_d  = alu_in;
        mem_wdata_d = aux_in ? {sdata_in[7:0], sdata_in[7:0]} : sdata_in;
        mem_be_d    = aux_in ? (alu_in[0] ? 2'b10 : 2'b01) : 2'b11;
        lreg_we_d   = reg_we_in;
        laux_d      = aux_in;
        lwa_d       = wa_in;
`ifdef MEM_TIMEOUT_EN
        cnt_d       = 8'd0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= 16'h0000;
      mem_wdata_q <= 16'h0000;
      mem_be_q    <= 2'b00;
      lreg_we_q   <= 1'b0;
      laux_q      <= 1'b0;
      lwa_q       <= 5'd0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_addr_q   <= 5'd0;
      wb_data_q   <= 16'h0000;
      err_q       <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_we_q   <= 1'b0;
      pend_addr_q <= 5'd0;
      pend_data_q <= 16'h0000;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      lreg_we_q   <= lreg_we_d;
      laux_q      <= laux_d;
      lwa_q       <= lwa_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
      pend_vld_q  <= pend_vld_d;
      pend_we_q   <= pend_we_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_wr    = mem_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign wb_valid  = wb_valid_q;
  assign wb_we     = wb_we_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
`ifdef MEM_TIMEOUT_EN
  assign err_out   = err_q;
`else
  assign err_out   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed latency/boundary cases, then randomized traffic against an in-order writeback scoreboard.
module tb_mem_wb_stage;

  typedef struct packed {
    logic        reg_we, store_pc, bypass, we, aux;
    logic [4:0]  wa;
    logic [15:0] alu, sd, pc;
  } instr_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [15:0] data;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst, valid_in, mem_ack;
  logic [15:0] mem_rdata;
  instr_t      ins;
  logic        mem_req, mem_wr, stall_out, wb_valid, wb_we, err_out;
  logic [15:0] mem_addr, mem_wdata, wb_data;
  logic [1:0]  mem_be;
  logic [4:0]  wb_addr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in),
    .reg_we_in(ins.reg_we), .store_pc_in(ins.store_pc), .mem_bypass_in(ins.bypass),
    .mem_we_in(ins.we), .aux_in(ins.aux), .wa_in(ins.wa),
    .alu_in(ins.alu), .sdata_in(ins.sd), .pc_in(ins.pc),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .stall_out(stall_out),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .err_out(err_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic instr_t mk(input logic reg_we, store_pc, bypass, we, aux,
                                input logic [4:0] wa, input logic [15:0] alu, sd, pc);
    mk = '{reg_we: reg_we, store_pc: store_pc, bypass: bypass, we: we, aux: aux,
           wa: wa, alu: alu, sd: sd, pc: pc};
  endfunction

  function automatic logic [1:0] ref_be(input instr_t i);
    if (!i.aux) return 2'b11;
    return i.alu[0] ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [15:0] ref_wdata(input instr_t i);
    return i.aux ? {i.sd[7:0], i.sd[7:0]} : i.sd;
  endfunction

  function automatic wb_t ref_bypass(input instr_t i);
    return '{we: i.reg_we, addr: i.wa, data: (i.store_pc ? i.pc : i.alu)};
  endfunction

  function automatic wb_t ref_mem(input instr_t i, input logic [15:0] rd);
    logic [15:0] ld;
    if (!i.aux)         ld = rd;
    else if (i.alu[0])  ld = rd >> 8;
    else                ld = rd & 16'h00FF;
    return '{we: (i.reg_we && !i.we), addr: i.wa, data: (i.we ? i.alu : ld)};
  endfunction

  wb_t         exp_q[$];
  wb_t         e;
  instr_t      bi;
  logic        busy, hold, accept;
  int          wait_cnt;
  logic [63:0] r;

  initial begin
    rst = 1'b1; valid_in = 1'b0; ins = '0; mem_ack = 1'b0; mem_rdata = 16'h0000;
    tick; tick;
    check("rst_ctl", {mem_req, mem_wr, mem_be, stall_out, wb_valid, wb_we, err_out}, 0);
    check("rst_mem", {mem_addr, mem_wdata}, 0);
    check("rst_wb", {wb_addr, wb_data}, 0);
    rst = 1'b0;

    // bypass, latency 1
    ins = mk(1, 0, 1, 0, 0, 5'd5, 16'h1234, 16'h0, 16'h0); valid_in = 1'b1;
    @(negedge clk) check("byp_stall", stall_out, 0);
    tick; valid_in = 1'b0;
    check("byp_wb", {wb_valid, wb_we, wb_addr, wb_data}, {1'b1, 1'b1, 5'd5, 16'h1234});
    tick;
    check("byp_pulse", {wb_valid, wb_we}, 0);

    // word load, ack in the third ACCESS cycle
    ins = mk(1, 0, 0, 0, 0, 5'd3, 16'h0040, 16'h0, 16'h0); valid_in = 1'b1;
    tick; valid_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("ld_req", {mem_req, mem_wr, mem_be, mem_addr}, {1'b1, 1'b0, 2'b11, 16'h0040});
      if (k == 2) begin mem_ack = 1'b1; mem_rdata = 16'hBEEF; end
      @(negedge clk) check("ld_stall", stall_out, (k < 2));
      tick;
    end
    mem_ack = 1'b0;
    check("ld_wb", {mem_req, wb_valid, wb_we, wb_addr, wb_data}, {1'b0, 1'b1, 1'b1, 5'd3, 16'hBEEF});

    // byte store to odd address
    ins = mk(1, 0, 0, 1, 1, 5'd4, 16'h0011, 16'h00AB, 16'h0); valid_in = 1'b1;
    tick; valid_in = 1'b0;
    check("bst_req", {mem_req, mem_wr, mem_be, mem_wdata}, {1'b1, 1'b1, 2'b10, 16'hABAB});
    mem_ack = 1'b1;
    tick; mem_ack = 1'b0;
    check("bst_wb", {wb_valid, wb_we, wb_data}, {1'b1, 1'b0, 16'h0011});

    // byte load, immediate ack, bypass accepted in the ack cycle
    ins = mk(1, 0, 0, 0, 1, 5'd7, 16'h0010, 16'h0, 16'h0); valid_in = 1'b1;
    tick;
    check("bld_req", {mem_req, mem_be}, {1'b1, 2'b01});
    mem_ack = 1'b1; mem_rdata = 16'h7F80;
    ins = mk(1, 0, 1, 0, 0, 5'd9, 16'h5555, 16'h0, 16'h0);
    @(negedge clk) check("bld_stall", stall_out, 0);
    tick; mem_ack = 1'b0; valid_in = 1'b0;
    check("bld_wb", {wb_valid, wb_we, wb_addr, wb_data}, {1'b1, 1'b1, 5'd7, 16'h0080});
    tick;
    check("b2b_wb", {wb_valid, wb_addr, wb_data}, {1'b1, 5'd9, 16'h5555});
    tick;
    check("b2b_pulse", {wb_valid, wb_we, mem_req}, 0);

    // reset mid-ACCESS, then a late ack
    ins = mk(1, 0, 0, 0, 0, 5'd2, 16'h0100, 16'h0, 16'h0); valid_in = 1'b1;
    tick; valid_in = 1'b0; rst = 1'b1;
    tick; rst = 1'b0;
    check("rst_abort", {mem_req, mem_wr, mem_be, stall_out, wb_valid, wb_we, err_out}, 0);
    check("rst_abort_mem", {mem_addr, mem_wdata}, 0);
    mem_ack = 1'b1; mem_rdata = 16'h1111;
    tick; mem_ack = 1'b0;
    check("late_ack", {mem_req, wb_valid, wb_we}, 0);

`ifdef MEM_TIMEOUT_EN
    ins = mk(1, 0, 0, 0, 0, 5'd6, 16'h0200, 16'h0, 16'h0); valid_in = 1'b1;
    tick; valid_in = 1'b0;
    for (int k = 0; k < 15; k++) begin
      check("tmo_req", mem_req, 1);
      tick;
    end
    check("tmo_end", {mem_req, err_out, wb_valid, wb_we}, {1'b0, 1'b1, 1'b1, 1'b0});
    tick;
    check("tmo_pulse", {err_out, wb_valid}, 0);
`endif

    // randomized traffic; ack forced within a few cycles so no timeout can fire
    busy = 1'b0; hold = 1'b0; wait_cnt = 0; bi = '0;
    for (int c = 0; c < 3000; c++) begin
      check("r_req", mem_req, busy);
      if (busy) begin
        check("r_addr", mem_addr, bi.alu);
        check("r_mctl", {mem_wr, mem_be, mem_wdata}, {bi.we, ref_be(bi), ref_wdata(bi)});
      end
      if (wb_valid) begin
        if (exp_q.size() == 0) check("r_wb_extra", wb_valid, 0);
        else begin
          e = exp_q.pop_front();
          check("r_wb", {wb_we, wb_addr, wb_data}, e);
        end
      end else check("r_wb_we", wb_we, 0);
      check("r_err", err_out, 0);

      if (!hold) begin
        r = {$urandom(), $urandom()};
        ins = r[$bits(instr_t)-1:0];
        valid_in = (c < 2900) && ($urandom_range(0, 9) < 7);
      end
      if (busy) mem_ack = (wait_cnt >= 4) || ($urandom_range(0, 2) == 0);
      else      mem_ack = ($urandom_range(0, 4) == 0);
      mem_rdata = 16'($urandom());

      @(negedge clk) check("r_stall", stall_out, busy && !mem_ack);
      accept = valid_in && (!busy || mem_ack);
      if (busy && mem_ack) begin
        exp_q.push_back(ref_mem(bi, mem_rdata));
        busy = 1'b0;
        wait_cnt = 0;
      end else if (busy) wait_cnt++;
      if (accept) begin
        if (ins.bypass) exp_q.push_back(ref_bypass(ins));
        else begin
          busy = 1'b1;
          bi = ins;
          wait_cnt = 0;
        end
      end
      hold = valid_in && !accept;
      tick;
    end
    check("r_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
